// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_pkg
// Shared constants and helpers for the serial pattern detector:
//   DEF_N      - default maximum pattern length
//   DEF_CNT_W  - default match counter width
//   DEF_PAT    - default pattern loaded at reset ("1010", MSB sent first)
//   DEF_LEN_W  - width of the length input for the default N
//   clamp_len  - maps a raw length request onto the legal range 1..n
// -----------------------------------------------------------------------------
package seq_detector_pkg;

   localparam int               DEF_N     = 4;
   localparam int               DEF_CNT_W = 8;
   localparam logic [DEF_N-1:0] DEF_PAT   = 4'b1010;
   localparam int               DEF_LEN_W = $clog2(DEF_N + 1);

   // A zero length would never match; treat it as 1. Oversized lengths
   // collapse onto the full history width.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned n);
      if (len == 0) return 1;
      if (len > n)  return n;
      return len;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   - clock, rising edge
//   clear - synchronous clear, dominates inc
//   inc   - count up by one (ignored once saturated)
//   count - current value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Serial pattern detector with a run-time programmable pattern of length
// 1..N, overlapping or non-overlapping detection and a saturating match count.
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   en          - sample strobe; in is consumed only when en = 1
//   in          - serial data bit
//   load        - latch pattern_in / len_in and restart detection
//   pattern_in  - new pattern, right-aligned; bit [len-1] is expected first
//   len_in      - new pattern length (0 -> 1, >N -> N)
//   overlap     - 1: matched bits may seed the next match, 0: restart after match
//   out         - registered one-cycle match pulse
//   match_count - matches since reset or load, saturating
// -----------------------------------------------------------------------------
module seq_detector
   import seq_detector_pkg::*;
#(
   parameter int             N           = DEF_N,
   parameter int             CNT_W       = DEF_CNT_W,
   parameter logic [N-1:0]   DEF_PATTERN = DEF_PAT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in,
   input  logic                     load,
   input  logic [N-1:0]             pattern_in,
   input  logic [$clog2(N+1)-1:0]   len_in,
   input  logic                     overlap,
   output logic                     out,
   output logic [CNT_W-1:0]         match_count
);

   localparam int LEN_W = $clog2(N + 1);

   logic [N-1:0]     r_pat;
   logic [LEN_W-1:0] r_len;
   logic [N-1:0]     r_hist;
   logic [LEN_W-1:0] r_fill;
   logic             r_out;

   logic [N-1:0]     w_hist_next;
   logic [LEN_W-1:0] w_fill_next;
   logic [N-1:0]     w_mask;
   logic             w_match;
   logic             w_clear;

   // Match is judged on the post-shift history so the pulse lands on the
   // edge that samples the last pattern bit.
   assign w_hist_next = {r_hist[N-2:0], in};
   assign w_fill_next = (r_fill == LEN_W'(N)) ? r_fill : r_fill + LEN_W'(1);

   // NOTE: every always_comb output gets a default before any conditional
   // logic, so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
   end

   assign w_match = en && !load
                 && (w_fill_next >= r_len)
                 && (((w_hist_next ^ r_pat) & w_mask) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat  <= DEF_PATTERN;
         r_len  <= LEN_W'(N);
         r_hist <= '0;
         r_fill <= '0;
         r_out  <= 1'b0;
      end else if (load) begin
         r_pat  <= pattern_in;
         r_len  <= LEN_W'(clamp_len(32'(len_in), N));
         r_hist <= '0;
         r_fill <= '0;
         r_out  <= 1'b0;
      end else if (en) begin
         r_hist <= w_hist_next;
         // Non-overlap: stale history bits stay but are masked by fill = 0.
         r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
         r_out  <= w_match;
      end else begin
         r_out  <= 1'b0;
      end
   end

   assign w_clear = rst | load;

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .clear (w_clear),
      .inc   (w_match),
      .count (match_count)
   );

   assign out = r_out;

endmodule
